// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Stall/flush sequencer for the five-stage RV32I pipeline. Produces the
// per-stage load enables and bubble/flush strobes for the IF/ID, ID/EX,
// EX/MEM and MEM/WB buffers, plus free-running performance counters.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   imem_req / imem_resp     fetch outstanding / single-cycle completion pulse
//   dmem_req / dmem_resp     MEM access outstanding / completion pulse
//   id_rs1, id_rs2,
//   id_uses_rs1, id_uses_rs2 source operands of the instruction in ID
//   ex_valid, ex_is_load,
//   ex_rd, ex_redirect       state of the instruction in EX
//   load_*                   stage register enables
//   flush_if_id, flush_id_ex load a bubble instead of upstream contents
//   stall_cnt, bubble_cnt,
//   flush_cnt                32-bit wrapping event counters
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | no memory stall in the previous cycle
// WAIT_MEM | pipeline frozen waiting on imem and/or dmem
module pipeline_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_req,
    input  logic        imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        ex_redirect,
    output logic        load_pc,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic {RUN = 1'b0, WAIT_MEM = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        imem_done_q, dmem_done_q;
    logic [31:0] stall_cnt_q, bubble_cnt_q, flush_cnt_q;

    logic mem_stall, redirect, load_use, advance;
    logic redirect_row, load_use_row;

    // A response that arrived while the other side was still busy is
    // remembered in the done flag so it no longer holds the stall.
    assign mem_stall = (imem_req & ~imem_resp & ~imem_done_q)
                     | (dmem_req & ~dmem_resp & ~dmem_done_q);
    assign advance   = ~mem_stall;
    assign redirect  = ex_valid & ex_redirect;
    assign load_use  = ex_valid & ex_is_load & (ex_rd != 5'd0)
                     & ((id_uses_rs1 & (id_rs1 == ex_rd))
                      | (id_uses_rs2 & (id_rs2 == ex_rd)));

    // A redirect held in the frozen EX buffer only takes effect on the
    // release cycle, so both rows are qualified by advance.
    assign redirect_row = advance & redirect;
    assign load_use_row = advance & ~redirect & load_use;

    // State register, sticky flags and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RUN;
            imem_done_q  <= 1'b0;
            dmem_done_q  <= 1'b0;
            stall_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
            flush_cnt_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (advance) begin
                imem_done_q <= 1'b0;
                dmem_done_q <= 1'b0;
            end else begin
                if (imem_req && imem_resp) imem_done_q <= 1'b1;
                if (dmem_req && dmem_resp) dmem_done_q <= 1'b1;
            end
            if (mem_stall)    stall_cnt_q  <= stall_cnt_q  + 32'd1;
            if (load_use_row) bubble_cnt_q <= bubble_cnt_q + 32'd1;
            if (redirect_row) flush_cnt_q  <= flush_cnt_q  + 32'd1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mem_stall)  state_d = WAIT_MEM;
            WAIT_MEM: if (!mem_stall) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Output logic (Mealy); everything held low while reset is asserted
    always_comb begin
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (rst && !mem_stall) begin
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            if (redirect) begin
                load_pc     = 1'b1;
                load_if_id  = 1'b1;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF/ID, inject a bubble into ID/EX
                flush_id_ex = 1'b1;
            end else begin
                load_pc     = 1'b1;
                load_if_id  = 1'b1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req = 1'b0, imem_resp = 1'b0;
    logic        dmem_req = 1'b0, dmem_resp = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0;
    logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic        ex_valid = 1'b0, ex_is_load = 1'b0, ex_redirect = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        flush_if_id, flush_id_ex;
    logic [31:0] stall_cnt, bubble_cnt, flush_cnt;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // en = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
    //       flush_if_id, flush_id_ex}
    typedef struct {
        string       name;
        logic [6:0]  en;
        logic [31:0] sc, bc, fc;
    } exp_t;

    localparam logic [6:0] EN_STOP = 7'b00000_00;
    localparam logic [6:0] EN_RUN  = 7'b11111_00;
    localparam logic [6:0] EN_LU   = 7'b00111_01;
    localparam logic [6:0] EN_RDR  = 7'b11111_11;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Monitor: outputs are presented every cycle; sample 2 time units after
    // the driver updates inputs on the falling edge.
    always @(negedge clk) begin
        #2;
        if (exp_q.size() != 0) begin
            exp_t e;
            logic [6:0] act;
            e = exp_q.pop_front();
            act = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                   flush_if_id, flush_id_ex};
            checks++;
            if (act !== e.en) begin
                failures++;
                $display("FAIL %s enables actual=%b required=%b", e.name, act, e.en);
            end
            checks++;
            if (stall_cnt !== e.sc) begin
                failures++;
                $display("FAIL %s stall_cnt actual=%h required=%h", e.name, stall_cnt, e.sc);
            end
            checks++;
            if (bubble_cnt !== e.bc) begin
                failures++;
                $display("FAIL %s bubble_cnt actual=%h required=%h", e.name, bubble_cnt, e.bc);
            end
            checks++;
            if (flush_cnt !== e.fc) begin
                failures++;
                $display("FAIL %s flush_cnt actual=%h required=%h", e.name, flush_cnt, e.fc);
            end
        end
    end

    // One cycle of stimulus plus its expected response.
    // mem = {imem_req, imem_resp, dmem_req, dmem_resp}
    // ex  = {ex_valid, ex_is_load, ex_redirect}
    // id  = {id_uses_rs1, id_uses_rs2}
    task automatic step(input string name, input logic r, input logic [3:0] mem,
                        input logic [2:0] ex, input logic [4:0] rd,
                        input logic [1:0] id, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [6:0] en, input logic [31:0] sc,
                        input logic [31:0] bc, input logic [31:0] fc);
        exp_t e;
        @(negedge clk);
        rst = r;
        {imem_req, imem_resp, dmem_req, dmem_resp} = mem;
        {ex_valid, ex_is_load, ex_redirect} = ex;
        ex_rd = rd;
        {id_uses_rs1, id_uses_rs2} = id;
        id_rs1 = rs1;
        id_rs2 = rs2;
        e.name = name; e.en = en; e.sc = sc; e.bc = bc; e.fc = fc;
        exp_q.push_back(e);
    endtask

    initial begin
        // reset and idle
        step("rst_idle",   0, 4'b0000, 3'b000, 0, 2'b00, 0, 0, EN_STOP, 0, 0, 0);
        step("idle",       1, 4'b0000, 3'b000, 0, 2'b00, 0, 0, EN_RUN,  0, 0, 0);
        // load-use
        step("lu_rs1",     1, 4'b0000, 3'b110, 5, 2'b10, 5, 0, EN_LU,   0, 0, 0);
        step("lu_after",   1, 4'b0000, 3'b000, 0, 2'b00, 0, 0, EN_RUN,  0, 1, 0);
        step("lu_rd0",     1, 4'b0000, 3'b110, 0, 2'b10, 0, 0, EN_RUN,  0, 1, 0);
        step("lu_rs2",     1, 4'b0000, 3'b110, 7, 2'b01, 3, 7, EN_LU,   0, 1, 0);
        step("lu2_after",  1, 4'b0000, 3'b000, 0, 2'b00, 0, 0, EN_RUN,  0, 2, 0);
        // redirect beats load-use; invalid EX redirect is ignored
        step("rdr_lu",     1, 4'b0000, 3'b111, 5, 2'b10, 5, 0, EN_RDR,  0, 2, 0);
        step("rdr_after",  1, 4'b0000, 3'b000, 0, 2'b00, 0, 0, EN_RUN,  0, 2, 1);
        step("rdr_inval",  1, 4'b0000, 3'b001, 0, 2'b00, 0, 0, EN_RUN,  0, 2, 1);
        // split responses: imem at c2, dmem at c5
        step("split_c0",   1, 4'b1010, 3'b000, 0, 2'b00, 0, 0, EN_STOP, 0, 2, 1);
        step("split_c1",   1, 4'b1010, 3'b000, 0, 2'b00, 0, 0, EN_STOP, 1, 2, 1);
        step("split_c2",   1, 4'b1110, 3'b000, 0, 2'b00, 0, 0, EN_STOP, 2, 2, 1);
        step("split_c3",   1, 4'b1010, 3'b000, 0, 2'b00, 0, 0, EN_STOP, 3, 2, 1);
        step("split_c4",   1, 4'b1010, 3'b000, 0, 2'b00, 0, 0, EN_STOP, 4, 2, 1);
        step("split_c5",   1, 4'b1011, 3'b000, 0, 2'b00, 0, 0, EN_RUN,  5, 2, 1);
        step("flag_clr",   1, 4'b1000, 3'b000, 0, 2'b00, 0, 0, EN_STOP, 5, 2, 1);
        // same-cycle response advances and sets no flag
        step("same_resp",  1, 4'b1100, 3'b000, 0, 2'b00, 0, 0, EN_RUN,  6, 2, 1);
        step("no_flag",    1, 4'b1000, 3'b000, 0, 2'b00, 0, 0, EN_STOP, 6, 2, 1);
        step("same_resp2", 1, 4'b1100, 3'b000, 0, 2'b00, 0, 0, EN_RUN,  7, 2, 1);
        step("idle2",      1, 4'b0000, 3'b000, 0, 2'b00, 0, 0, EN_RUN,  7, 2, 1);
        // redirect held during a 3-cycle dmem stall
        step("rdr_stall0", 1, 4'b0010, 3'b101, 0, 2'b00, 0, 0, EN_STOP, 7, 2, 1);
        step("rdr_stall1", 1, 4'b0010, 3'b101, 0, 2'b00, 0, 0, EN_STOP, 8, 2, 1);
        step("rdr_stall2", 1, 4'b0010, 3'b101, 0, 2'b00, 0, 0, EN_STOP, 9, 2, 1);
        step("rdr_release",1, 4'b0011, 3'b101, 0, 2'b00, 0, 0, EN_RDR, 10, 2, 1);
        step("rdr_done",   1, 4'b0000, 3'b000, 0, 2'b00, 0, 0, EN_RUN, 10, 2, 2);
        // reset mid-stall with imem_done set
        step("w_stall0",   1, 4'b1010, 3'b000, 0, 2'b00, 0, 0, EN_STOP,10, 2, 2);
        step("w_iresp",    1, 4'b1110, 3'b000, 0, 2'b00, 0, 0, EN_STOP,11, 2, 2);
        step("w_rst",      0, 4'b1010, 3'b000, 0, 2'b00, 0, 0, EN_STOP, 0, 0, 0);
        step("w_fresh0",   1, 4'b1000, 3'b000, 0, 2'b00, 0, 0, EN_STOP, 0, 0, 0);
        step("w_fresh1",   1, 4'b1000, 3'b000, 0, 2'b00, 0, 0, EN_STOP, 1, 0, 0);
        step("w_idle",     1, 4'b0000, 3'b000, 0, 2'b00, 0, 0, EN_RUN,  2, 0, 0);
        // counter wrap: preset stall counter to all ones between edges
        @(posedge clk);
        #1 force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.stall_cnt_q;
        step("wrap_pre",   1, 4'b1000, 3'b000, 0, 2'b00, 0, 0, EN_STOP, 32'hFFFF_FFFF, 0, 0);
        step("wrap_post",  1, 4'b0000, 3'b000, 0, 2'b00, 0, 0, EN_RUN,  0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
